pcm_frame_buffer: RTL and testbench

Stereo PCM frame FIFO between the FIR/sample-rate stage and the PCM-to-I2S serializer. It accepts 24-bit L/R frame pairs from upstream on a valid/ready handshake. It releases one frame per I2S frame period, paced by the serializer's level-type `l_data_en`/`r_data_en` requests. Prefill, underrun and overflow are handled explicitly so the I2S output never glitches on rate mismatch.

---
 rtl/pcm_frame_buffer_if.sv | 35 +++
 rtl/pcm_frame_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_pcm_frame_buffer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_frame_buffer_if.sv
// Signal bundle between upstream sample source, pcm_frame_buffer and the I2S serializer.
// master = upstream/serializer side, slave = the frame buffer itself.
`timescale 1ns/1ps

interface pcm_frame_buffer_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_l;
    logic [DATA_W-1:0] in_r;
    logic              l_data_en;
    logic              r_data_en;
    logic [DATA_W-1:0] l_data;
    logic [DATA_W-1:0] r_data;
    logic              l_data_valid;
    logic              r_data_valid;
    logic [ADDR_W:0]   fill_level;
    logic              underrun;
    logic              overflow;
    logic              clear_flags;

    modport master (
        output in_valid, in_l, in_r, l_data_en, r_data_en, clear_flags,
        input  in_ready, l_data, r_data, l_data_valid, r_data_valid,
               fill_level, underrun, overflow
    );

    modport slave (
        input  in_valid, in_l, in_r, l_data_en, r_data_en, clear_flags,
        output in_ready, l_data, r_data, l_data_valid, r_data_valid,
               fill_level, underrun, overflow
    );
endinterface

// File: rtl/pcm_frame_buffer.sv
// Stereo PCM frame FIFO with prefill, underrun and overflow handling, paced by I2S load requests.
// Optional macro PCM_FIFO_UNDERRUN_HOLD_EN: repeat the last frame on underrun instead of muting.
`timescale 1ns/1ps

module pcm_frame_buffer #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 4,
    parameter int PREFILL = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pcm_frame_buffer_if.slave     bus
);

    typedef enum logic {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam int              DEPTH       = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PREFILL_LVL = (ADDR_W+1)'(PREFILL);

    state_t r_state;
    state_t w_state_next;

    logic [2*DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_rptr;
    logic [ADDR_W:0]     r_fill;

    logic r_l_en_q;
    logic r_l_en_d;
    logic r_r_en_q;
    logic r_r_en_d;

    logic [DATA_W-1:0] r_l_data;
    logic [DATA_W-1:0] r_r_data;
    logic [DATA_W-1:0] r_r_stage;
    logic              r_l_valid;
    logic              r_r_valid;
    logic              r_underrun;
    logic              r_overflow;

    logic                w_l_rise;
    logic                w_r_rise;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic                w_prime_load;
    logic                w_underrun_evt;
    logic [2*DATA_W-1:0] w_rd_entry;

    assign w_full     = (r_fill == FULL_LVL);
    assign w_empty    = (r_fill == '0);
    assign w_push     = bus.in_valid && !w_full;
    assign w_drop     = bus.in_valid && w_full;
    assign w_l_rise   = r_l_en_q && !r_l_en_d;
    assign w_r_rise   = r_r_en_q && !r_r_en_d;
    assign w_rd_entry = r_mem[r_rptr];

    // Requests are registered before edge detection, giving a two-clock request-to-output latency.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_l_en_q <= 1'b0;
            r_l_en_d <= 1'b0;
            r_r_en_q <= 1'b0;
            r_r_en_d <= 1'b0;
        end else begin
            r_l_en_q <= bus.l_data_en;
            r_l_en_d <= r_l_en_q;
            r_r_en_q <= bus.r_data_en;
            r_r_en_d <= r_r_en_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pop          = 1'b0;
        w_prime_load   = 1'b0;
        w_underrun_evt = 1'b0;
        case (r_state)
            S_PRIME: begin
                w_prime_load = w_l_rise;
                if (r_fill >= PREFILL_LVL) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_l_rise) begin
                    if (w_empty) begin
                        w_underrun_evt = 1'b1;
                        w_state_next   = S_PRIME;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_PRIME;
            end
        endcase
    end

    // Frame storage carries no reset; validity is governed entirely by the pointers and fill count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.in_l, bus.in_r};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Right output is fed from r_stage so it always belongs to the frame last presented on the left.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_l_data  <= '0;
            r_r_stage <= '0;
            r_r_data  <= '0;
            r_l_valid <= 1'b0;
            r_r_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_l_data  <= w_rd_entry[2*DATA_W-1:DATA_W];
                r_r_stage <= w_rd_entry[DATA_W-1:0];
                r_l_valid <= 1'b1;
            end else if (w_prime_load) begin
                r_l_data  <= '0;
                r_r_stage <= '0;
                r_l_valid <= 1'b0;
            end else if (w_underrun_evt) begin
`ifdef PCM_FIFO_UNDERRUN_HOLD_EN
                r_l_data  <= r_l_data;
                r_r_stage <= r_r_stage;
`else
                r_l_data  <= '0;
                r_r_stage <= '0;
`endif
                r_l_valid <= 1'b0;
            end
            if (w_r_rise) begin
                r_r_data  <= r_r_stage;
                r_r_valid <= (r_state == S_RUN) ? r_l_valid : 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end else if (bus.clear_flags) begin
                r_underrun <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_flags) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = !w_full;
    assign bus.l_data       = r_l_data;
    assign bus.r_data       = r_r_data;
    assign bus.l_data_valid = r_l_valid;
    assign bus.r_data_valid = r_r_valid;
    assign bus.fill_level   = r_fill;
    assign bus.underrun     = r_underrun;
    assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_pcm_frame_buffer.sv
// Directed bench for pcm_frame_buffer with a frame-queue scoreboard and serializer request emulation.
// Build with +define+PCM_FIFO_UNDERRUN_HOLD_EN to expect the hold-on-underrun behaviour.
`timescale 1ns/1ps

module tb_pcm_frame_buffer;

    localparam int DATA_W  = 24;
    localparam int ADDR_W  = 4;
    localparam int PREFILL = 8;
    localparam int DEPTH   = 16;

    typedef enum {M_PRIME, M_RUN} modelState_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    pcm_frame_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    pcm_frame_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PREFILL(PREFILL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int passedChecks = 0;
    int totalChecks  = 0;
    int failedChecks = 0;

    logic [47:0]       modelQ[$];
    modelState_t       modelState;
    logic [DATA_W-1:0] modelL;
    logic [DATA_W-1:0] modelStage;
    logic [DATA_W-1:0] modelR;
    logic              modelLValid;
    logic              modelRValid;
    logic              modelUnderrun;
    logic              modelOverflow;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        assert (observed === expected) passedChecks++;
        else begin
            failedChecks++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelState    = M_PRIME;
        modelL        = '0;
        modelStage    = '0;
        modelR        = '0;
        modelLValid   = 1'b0;
        modelRValid   = 1'b0;
        modelUnderrun = 1'b0;
        modelOverflow = 1'b0;
    endtask

    task automatic modelPush(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        if (modelQ.size() < DEPTH) modelQ.push_back({l, r});
        else modelOverflow = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        checkOutput({tag, ".fill"}, 64'(bus.fill_level), 64'd0);
        checkOutput({tag, ".l_data"}, 64'(bus.l_data), 64'd0);
        checkOutput({tag, ".r_data"}, 64'(bus.r_data), 64'd0);
        checkOutput({tag, ".l_valid"}, 64'(bus.l_data_valid), 64'd0);
        checkOutput({tag, ".r_valid"}, 64'(bus.r_data_valid), 64'd0);
        checkOutput({tag, ".underrun"}, 64'(bus.underrun), 64'd0);
        checkOutput({tag, ".overflow"}, 64'(bus.overflow), 64'd0);
    endtask

    // One upstream push; in_ready is checked against the model before the frame is offered.
    task automatic applyStimulus(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input string tag);
        checkOutput({tag, ".in_ready"}, 64'(bus.in_ready), 64'(modelQ.size() < DEPTH));
        bus.in_valid = 1'b1;
        bus.in_l     = l;
        bus.in_r     = r;
        tick();
        bus.in_valid = 1'b0;
        modelPush(l, r);
        checkOutput({tag, ".fill"}, 64'(bus.fill_level), 64'(modelQ.size()));
        checkOutput({tag, ".overflow"}, 64'(bus.overflow), 64'(modelOverflow));
    endtask

    // One serializer frame period; optional push lands on the same clock as the left rise.
    task automatic serialFrame(input bit doPush, input logic [DATA_W-1:0] pl,
                               input logic [DATA_W-1:0] pr, input string tag);
        bus.l_data_en = 1'b1;
        tick();
        if (doPush) begin
            bus.in_valid = 1'b1;
            bus.in_l     = pl;
            bus.in_r     = pr;
        end
        tick();
        bus.in_valid = 1'b0;
        if (modelState == M_PRIME && modelQ.size() >= PREFILL) modelState = M_RUN;
        if (modelState == M_RUN) begin
            if (modelQ.size() > 0) begin
                {modelL, modelStage} = modelQ.pop_front();
                modelLValid = 1'b1;
            end else begin
                modelUnderrun = 1'b1;
                modelLValid   = 1'b0;
`ifndef PCM_FIFO_UNDERRUN_HOLD_EN
                modelL     = '0;
                modelStage = '0;
`endif
                modelState = M_PRIME;
            end
        end else begin
            modelL      = '0;
            modelStage  = '0;
            modelLValid = 1'b0;
        end
        if (doPush) modelPush(pl, pr);
        checkOutput({tag, ".l_data"}, 64'(bus.l_data), 64'(modelL));
        checkOutput({tag, ".l_valid"}, 64'(bus.l_data_valid), 64'(modelLValid));
        checkOutput({tag, ".fill"}, 64'(bus.fill_level), 64'(modelQ.size()));
        checkOutput({tag, ".underrun"}, 64'(bus.underrun), 64'(modelUnderrun));
        ticks(6);
        bus.l_data_en = 1'b0;
        ticks(2);
        bus.r_data_en = 1'b1;
        ticks(2);
        modelR      = modelStage;
        modelRValid = (modelState == M_RUN) ? modelLValid : 1'b0;
        checkOutput({tag, ".r_data"}, 64'(bus.r_data), 64'(modelR));
        checkOutput({tag, ".r_valid"}, 64'(bus.r_data_valid), 64'(modelRValid));
        ticks(6);
        bus.r_data_en = 1'b0;
        ticks(2);
    endtask

    task automatic clearFlags(input string tag);
        bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        modelUnderrun = 1'b0;
        modelOverflow = 1'b0;
        checkOutput({tag, ".underrun"}, 64'(bus.underrun), 64'd0);
        checkOutput({tag, ".overflow"}, 64'(bus.overflow), 64'd0);
    endtask

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_l        = '0;
        bus.in_r        = '0;
        bus.l_data_en   = 1'b0;
        bus.r_data_en   = 1'b0;
        bus.clear_flags = 1'b0;
        modelReset();

        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        checkResetState("reset");

        // Prefill: seven frames are not enough to start playback.
        for (int k = 0; k < 7; k++) applyStimulus(24'h000100 + 24'(k), 24'h800100 + 24'(k), "prefill");
        serialFrame(1'b0, '0, '0, "prime7");
        applyStimulus(24'h000107, 24'h800107, "prefill8");
        serialFrame(1'b0, '0, '0, "first");

        // Pairing across the remaining frames and a pointer wrap.
        for (int k = 8; k < 16; k++) applyStimulus(24'h000100 + 24'(k), 24'h800100 + 24'(k), "fill16");
        for (int k = 1; k < 16; k++) serialFrame(1'b0, '0, '0, "pair");

        // Underrun from an empty FIFO, then PRIME zero-load on the next request.
        serialFrame(1'b0, '0, '0, "underrun");
        serialFrame(1'b0, '0, '0, "primeAfterUnderrun");
        clearFlags("clrUnderrun");

        // Overflow: a seventeenth frame is dropped.
        for (int k = 0; k < 16; k++) applyStimulus(24'h000200 + 24'(k), 24'h800200 + 24'(k), "ovfFill");
        applyStimulus(24'h0002FF, 24'h8002FF, "ovfDrop");
        clearFlags("clrOverflow");

        // Simultaneous push and pop at fill 5, then at fill 0 in RUN.
        for (int k = 0; k < 11; k++) serialFrame(1'b0, '0, '0, "drainTo5");
        serialFrame(1'b1, 24'h000300, 24'h800300, "simul5");
        for (int k = 0; k < 5; k++) serialFrame(1'b0, '0, '0, "drainTo0");
        serialFrame(1'b1, 24'h000301, 24'h800301, "simul0");
        clearFlags("clrSimul");

        // Mid-operation reset with ten frames stored.
        for (int k = 0; k < 9; k++) applyStimulus(24'h000400 + 24'(k), 24'h800400 + 24'(k), "fill10");
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        modelReset();
        checkResetState("midReset");
        serialFrame(1'b0, '0, '0, "postReset");
        for (int k = 0; k < 8; k++) applyStimulus(24'h000500 + 24'(k), 24'h800500 + 24'(k), "refill");
        serialFrame(1'b0, '0, '0, "restart");

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
